// File: rtl/redmule_load_rob.sv
// Reorder buffer for one streamer TCDM channel: tags requests with a slot ID and
// returns responses in issue order. Define REDMULE_ROB_BYPASS_EN for a 0-cycle head-slot bypass.
module redmule_load_rob #(
  parameter int unsigned DW  = 256,
  parameter int unsigned AW  = 32,
  parameter int unsigned NW  = 8,
  localparam int unsigned IDW = $clog2(NW)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            in_req_valid_i,
  output logic            in_req_ready_o,
  input  logic [AW-1:0]   in_req_add_i,
  input  logic            in_req_wen_i,
  input  logic [DW-1:0]   in_req_data_i,
  input  logic [DW/8-1:0] in_req_be_i,
  output logic            out_req_valid_o,
  input  logic            out_req_ready_i,
  output logic [AW-1:0]   out_req_add_o,
  output logic            out_req_wen_o,
  output logic [DW-1:0]   out_req_data_o,
  output logic [DW/8-1:0] out_req_be_o,
  output logic [IDW-1:0]  out_req_id_o,
  input  logic            out_resp_valid_i,
  input  logic [IDW-1:0]  out_resp_id_i,
  input  logic [DW-1:0]   out_resp_data_i,
  output logic            in_resp_valid_o,
  input  logic            in_resp_ready_i,
  output logic [DW-1:0]   in_resp_data_o,
  output logic [IDW:0]    cnt_o,
  output logic            empty_o,
  output logic            err_o
);

  localparam logic [IDW:0] FULL = (IDW+1)'(NW);

  logic [IDW-1:0] wptr, rptr;
  logic [IDW:0]   cnt;
  logic [NW-1:0]  vld;
  logic [DW-1:0]  mem [NW];
  logic           err;
  logic           not_full, req_hs, resp_hs, head_vld, byp, store, resp_err;

  assign not_full        = (cnt != FULL);
  assign out_req_valid_o = in_req_valid_i && not_full;
  assign in_req_ready_o  = out_req_ready_i && not_full;
  assign req_hs          = in_req_valid_i && out_req_ready_i && not_full;

  assign out_req_add_o  = in_req_add_i;
  assign out_req_wen_o  = in_req_wen_i;
  assign out_req_data_o = in_req_data_i;
  assign out_req_be_o   = in_req_be_i;
  assign out_req_id_o   = wptr;

  assign head_vld = vld[rptr];

`ifdef REDMULE_ROB_BYPASS_EN
  // Bypass only when a slot is actually outstanding, so cnt can never underflow.
  assign byp             = out_resp_valid_i && (out_resp_id_i == rptr) && !head_vld && (cnt != '0);
  assign in_resp_valid_o = head_vld || byp;
  assign in_resp_data_o  = head_vld ? mem[rptr] : out_resp_data_i;
`else
  assign byp             = 1'b0;
  assign in_resp_valid_o = head_vld;
  assign in_resp_data_o  = mem[rptr];
`endif

  assign resp_hs  = in_resp_valid_o && in_resp_ready_i;
  assign store    = out_resp_valid_i && !clear_i && !(byp && in_resp_ready_i);
  assign resp_err = out_resp_valid_i && (vld[out_resp_id_i] || (cnt == '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      vld  <= '0;
      err  <= 1'b0;
    end else if (clear_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      vld  <= '0;
      err  <= 1'b0;
    end else begin
      if (req_hs)  wptr <= wptr + 1'b1;
      if (resp_hs) rptr <= rptr + 1'b1;
      case ({req_hs, resp_hs})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // Release is ordered after the store so a same-slot collision leaves the slot free.
      if (store)   vld[out_resp_id_i] <= 1'b1;
      if (resp_hs) vld[rptr] <= 1'b0;
      if (resp_err) err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) mem[out_resp_id_i] <= out_resp_data_i;
  end

  assign cnt_o   = cnt;
  assign empty_o = (cnt == '0);
  assign err_o   = err;

endmodule
